// File: rtl/red_pitaya_pwm_dac.sv
// -----------------------------------------------------------------------------
// red_pitaya_pwm_dac
//
// Four-channel PWM generator that feeds the external RC filters of the slow
// analog outputs. Each 24-bit configuration word holds an 8-bit base duty D
// in [23:16] and a 16-bit dither mask M in [15:0]. With dithering enabled,
// a frame is 16 PWM periods, and period k is stretched by one clock when M[k]
// is set, so the mean level is (16*D + popcount(M)) / (16*FULL).
//
// Parameters:
//   FULL      PWM period length in clocks, legal range 2..256.
//
// Ports:
//   clk_i     PWM clock, single clock domain.
//   rst_i     synchronous, active-high reset.
//   cfg_a_i   channel A word: [23:16] base duty, [15:0] dither mask.
//   cfg_b_i   channel B word, same format.
//   cfg_c_i   channel C word, same format.
//   cfg_d_i   channel D word, same format.
//   pwm_o     registered PWM outputs, bit 0 = A ... bit 3 = D.
//   frame_o   one-cycle pulse in the cycle the new frame's words are latched.
//
// Build option:
//   PWM_DITHER_EN  when defined, enables the 16-bit dither mask and the
//                  16-period frame. When undefined, the mask is ignored, the
//                  duty is D, and every period is a frame.
// -----------------------------------------------------------------------------
module red_pitaya_pwm_dac #(
    parameter int unsigned FULL = 156
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] cfg_a_i,
    input  logic [23:0] cfg_b_i,
    input  logic [23:0] cfg_c_i,
    input  logic [23:0] cfg_d_i,
    output logic [3:0]  pwm_o,
    output logic        frame_o
);

    localparam logic [7:0] CntMax = 8'(FULL - 1);

    logic [23:0] cfg [4];
    logic [7:0]  cnt_q;
    logic [8:0]  dty_q [4];
    logic        period_end;
    logic        frame_end;

    assign cfg[0] = cfg_a_i;
    assign cfg[1] = cfg_b_i;
    assign cfg[2] = cfg_c_i;
    assign cfg[3] = cfg_d_i;

    assign period_end = (cnt_q == CntMax);

`ifdef PWM_DITHER_EN

    logic [3:0]  bcnt_q;
    logic [3:0]  bcnt_next;
    logic [23:0] shadow_q [4];

    assign bcnt_next = bcnt_q + 4'd1;
    assign frame_end = period_end && (bcnt_q == 4'd15);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt_q <= '0;
        end else if (period_end) begin
            bcnt_q <= bcnt_next;
        end
    end

    // At the frame boundary the new word bypasses the shadow so that period 0
    // of the new frame already uses it. Mid-frame reloads read the shadow
    // only, which keeps writes to cfg_*_i glitch-free.
    always_ff @(posedge clk_i) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (rst_i || frame_end) begin
                shadow_q[ch] <= cfg[ch];
                dty_q[ch]    <= {1'b0, cfg[ch][23:16]} + 9'(cfg[ch][0]);
            end else if (period_end) begin
                dty_q[ch]    <= {1'b0, shadow_q[ch][23:16]}
                              + 9'(shadow_q[ch][{1'b0, bcnt_next}]);
            end
        end
    end

`else

    logic unused_mask;

    // Every period end is a frame boundary. The duty register captures D at
    // that point and holds it for the whole period, so it doubles as the
    // shadow.
    assign frame_end   = period_end;
    assign unused_mask = ^{cfg[0][15:0], cfg[1][15:0], cfg[2][15:0], cfg[3][15:0]};

    always_ff @(posedge clk_i) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (rst_i || frame_end) begin
                dty_q[ch] <= {1'b0, cfg[ch][23:16]};
            end
        end
    end

`endif

    // 9-bit compare: a duty of FULL or more keeps the output high for the whole
    // period without wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            pwm_o   <= '0;
            frame_o <= 1'b0;
        end else begin
            cnt_q   <= period_end ? 8'd0 : cnt_q + 8'd1;
            frame_o <= frame_end;
            for (int ch = 0; ch < 4; ch++) begin
                pwm_o[ch] <= ({1'b0, cnt_q} < dty_q[ch]);
            end
        end
    end

endmodule

// File: doc/red_pitaya_pwm_dac.md
# red_pitaya_pwm_dac

Four-channel PWM generator for the analog-mixed-signal section. It is the consumer end of the 24-bit PWM DAC configuration words that the AMS register block exposes as `dac_a_o`..`dac_d_o`. Each word encodes an 8-bit base duty and a 16-bit dither mask spread over a 16-period frame. The resulting `pwm_o` lines drive the external RC filters of the slow analog outputs.

## Interface
- `FULL`, 156: PWM period length in clocks; legal range 2..256.
- `clk_i`  in  1  PWM clock; all logic in this single domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `cfg_a_i`  in  24  channel A word; [23:16] base duty D, [15:0] dither mask M.
- `cfg_b_i`  in  24  channel B word, same format.
- `cfg_c_i`  in  24  channel C word, same format.
- `cfg_d_i`  in  24  channel D word, same format.
- `pwm_o`  out  4  PWM outputs, bit 0 = A … bit 3 = D; registered.
- `frame_o`  out  1  one-cycle pulse marking the first cycle of a new frame.

## Operation
- Period counter `cnt` (8 bit) counts 0..FULL-1 and wraps to 0.
- Bit counter `bcnt` (4 bit) advances when `cnt`==FULL-1 and wraps 15→0. A frame is 16 periods.
- Shadow registers, one 24-bit register per channel:
  - loaded from `cfg_*_i` in the cycle where `cnt`==FULL-1 and `bcnt`==15 (frame boundary);
  - `cfg_*_i` is ignored at all other times, so mid-frame writes are glitch-free.
- Duty register `dty` (9 bit) per channel, reloaded when `cnt`==FULL-1:
  - `dty` = D + M[k], where k is the index of the next period (LSB first);
  - at a frame boundary, D and M come directly from the incoming `cfg_*_i`, the same values being latched into the shadow.
- Output rule: `pwm_o[ch]` <= (`cnt` < `dty[ch]`), a 9-bit unsigned compare.
  - `dty` ≥ FULL gives constant high; no wrap or overflow.
  - `dty` = 0 gives constant low.
- Mean level = (16·D + popcount(M)) / (16·FULL), saturating at 1.
- `frame_o` <= 1 in the cycle where the shadow load occurs. It is therefore high during the first output cycle of the new frame.
- Reset (`rst_i`=1):
  - `cnt`=0, `bcnt`=0, `pwm_o`=4'b0000, `frame_o`=0;
  - shadows load `cfg_*_i` every cycle;
  - `dty` = D + M[0] of the current inputs.
- Reset asserted mid-operation: outputs go low at the next edge and the frame restarts from period 0 on release. No partial frame state survives.

## Timing
- Registered outputs. `pwm_o` at edge t+1 reflects `cnt` at edge t.
- First edge after `rst_i` falls: `pwm_o[ch]`=1 if `dty[ch]`>0.
- Each period has exactly `dty` high cycles followed by FULL−`dty` low cycles, starting at the first cycle of the period.
- Configuration latency:
  - new `cfg_*_i` takes effect in the first period after the next frame boundary;
  - worst case 16·FULL cycles; best case 1 cycle (value present at the boundary cycle).
- `frame_o` period = 16·FULL cycles. The first pulse comes at output cycle 16·FULL after reset release.
- Simultaneous events: at a frame boundary the shadow load and the `dty` reload occur in the same cycle, and both use the new `cfg`.

## Configuration
- `PWM_DITHER_EN` defined:
  - full behaviour above (16-bit mask, `bcnt`, 16-period frame).
- `PWM_DITHER_EN` undefined:
  - `bcnt` and M are removed; `dty` = D;
  - every period end is a frame boundary, so shadows load and `frame_o` pulses once per FULL cycles;
  - `cfg_*_i[15:0]` is ignored.

## Test plan
- Reset values: `cfg_a_i`=0x0F_0000, release `rst_i` → `pwm_o[0]` high at edge 1; 15 high / 141 low cycles, repeating every 156; `frame_o` pulses at cycles 2496, 4992, ….
- Dither: `cfg_b_i`=0x4E_0001 → period 0 has 79 high cycles, periods 1..15 have 78; frame total 1249. Repeat with 0x4E_8000 → only period 15 has 79.
- Saturation and edges:
  - 0x9C_FFFF and 0xFF_0000 → `pwm_o` constant high;
  - 0x00_0000 → constant low;
  - 0x00_FFFF → exactly 1 high cycle every period.
- Mid-frame change: switch `cfg_c_i` 0x75_0000→0x10_0000 during period 5 → duty stays 117 through period 15; 16 from the cycle `frame_o` asserts.
- Reset mid-period: assert `rst_i` at `cnt`=40 of period 7 for 3 cycles → `pwm_o`=0 and `frame_o`=0 during reset; restart at period 0, first `frame_o` 2496 cycles after release.
- `PWM_DITHER_EN` undefined: `cfg_d_i`=0x4E_FFFF → 78 high every period; change to 0x20_0000 mid-period → 32 high from the next period; `frame_o` every 156 cycles.
